// File: rtl/tinyodin_obi_loader.sv
// tinyodin_obi_loader
// OBI initiator that copies len_i words from system memory into the tinyODIN
// spike-core window, one read/write pair at a time. It then writes a command
// word to the tinyODIN control register and waits for the finished interrupt.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   start_i                  start request, sampled only while idle
//   abort_i                  abort request, latched until the FSM returns idle
//   src_addr_i, dst_addr_i   word-aligned source / destination base addresses
//   len_i                    number of words to copy (0 = command only)
//   ctrl_addr_i, ctrl_data_i control register address and command word
//   intr_ODIN_finished_i     tinyODIN finished interrupt (level)
//   req_o/gnt_i/addr_o/we_o/be_o/wdata_o/rvalid_i/rdata_i  OBI initiator port
//   busy_o                   high in every state except IDLE
//   done_o, aborted_o        one-cycle completion pulses (mutually exclusive)
module tinyodin_obi_loader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [ADDR_W-1:0]   src_addr_i,
    input  logic [ADDR_W-1:0]   dst_addr_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic [ADDR_W-1:0]   ctrl_addr_i,
    input  logic [DATA_W-1:0]   ctrl_data_i,
    input  logic                intr_ODIN_finished_i,
    output logic                req_o,
    input  logic                gnt_i,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                we_o,
    output logic [DATA_W/8-1:0] be_o,
    output logic [DATA_W-1:0]   wdata_o,
    input  logic                rvalid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o
);

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP,
        CMD_REQ,
        CMD_RSP,
        WAIT_FIN,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] src_reg, dst_reg, ctrl_addr_reg;
    logic [DATA_W-1:0] ctrl_data_reg, buf_reg;
    logic [LEN_W-1:0]  len_reg, idx_reg;
    logic              abort_reg;

    logic              abort_any;
    logic              last_word;
    logic [LEN_W-1:0]  idx_inc;
    logic [ADDR_W-1:0] word_off;

    // An abort raised in the very cycle a response completes still counts.
    assign abort_any = abort_reg | abort_i;
    assign idx_inc   = idx_reg + LEN_W'(1);
    assign last_word = (idx_inc == len_reg);
    // Byte offset of the current word; address sums wrap modulo 2^ADDR_W.
    assign word_off  = ADDR_W'(idx_reg) << 2;
    assign be_o      = {(DATA_W/8){1'b1}};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            len_reg       <= '0;
            ctrl_addr_reg <= '0;
            ctrl_data_reg <= '0;
            idx_reg       <= '0;
            buf_reg       <= '0;
            abort_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && start_i) begin
                src_reg       <= src_addr_i;
                dst_reg       <= dst_addr_i;
                len_reg       <= len_i;
                ctrl_addr_reg <= ctrl_addr_i;
                ctrl_data_reg <= ctrl_data_i;
                idx_reg       <= '0;
            end

            if (state_reg == RD_RSP && rvalid_i) begin
                buf_reg <= rdata_i;
            end

            if (state_reg == WR_RSP && rvalid_i) begin
                idx_reg <= idx_inc;
            end

            // The latch is cleared while idle so an abort seen there is
            // dropped; DONE keeps it so the pulse type stays decided.
            if (state_reg == IDLE) begin
                abort_reg <= 1'b0;
            end else if (state_reg != DONE && abort_i) begin
                abort_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        req_o      = 1'b0;
        we_o       = 1'b0;
        addr_o     = '0;
        wdata_o    = '0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        aborted_o  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_next = (len_i == '0) ? CMD_REQ : RD_REQ;
                end
            end
            RD_REQ: begin
                req_o  = 1'b1;
                addr_o = src_reg + word_off;
                if (gnt_i) state_next = RD_RSP;
            end
            RD_RSP: begin
                if (rvalid_i) state_next = abort_any ? DONE : WR_REQ;
            end
            WR_REQ: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                addr_o  = dst_reg + word_off;
                wdata_o = buf_reg;
                if (gnt_i) state_next = WR_RSP;
            end
            WR_RSP: begin
                if (rvalid_i) begin
                    if (abort_any)      state_next = DONE;
                    else if (last_word) state_next = CMD_REQ;
                    else                state_next = RD_REQ;
                end
            end
            CMD_REQ: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                addr_o  = ctrl_addr_reg;
                wdata_o = ctrl_data_reg;
                if (gnt_i) state_next = CMD_RSP;
            end
            CMD_RSP: begin
                if (rvalid_i) state_next = abort_any ? DONE : WAIT_FIN;
            end
            WAIT_FIN: begin
                // Abort takes priority over a simultaneous finish.
                if (abort_any || intr_ODIN_finished_i) state_next = DONE;
            end
            DONE: begin
                done_o     = ~abort_reg;
                aborted_o  = abort_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/tinyodin_obi_loader.md
Name: tinyodin_obi_loader

Overview:
- OBI initiator (master) that feeds the tinyODIN responder.
- Copies LEN words from system memory into the tinyODIN spike-core window, one word at a time.
- Then writes a start command word to the tinyODIN control register and waits for the finished interrupt.
- Sits between the host-side configuration registers and the system bus, so a full inference runs without CPU copy loops.

Parameters:
- ADDR_W, 32, OBI address width.
- DATA_W, 32, OBI data width; be_o is DATA_W/8 bits.
- LEN_W, 16, width of the word-count field.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- start_i  in  1  single-cycle start request; sampled only in IDLE.
- abort_i  in  1  abort request; level or pulse, latched until IDLE.
- src_addr_i  in  ADDR_W  word-aligned source base address.
- dst_addr_i  in  ADDR_W  word-aligned spike-core destination base address.
- len_i  in  LEN_W  number of words to copy.
- ctrl_addr_i  in  ADDR_W  tinyODIN control register address.
- ctrl_data_i  in  DATA_W  command word written to ctrl_addr_i after the copy.
- intr_ODIN_finished_i  in  1  tinyODIN finished interrupt, level.
- req_o  out  1  OBI request.
- gnt_i  in  1  OBI grant.
- addr_o  out  ADDR_W  OBI address.
- we_o  out  1  OBI write enable.
- be_o  out  DATA_W/8  byte enables; always all-ones.
- wdata_o  out  DATA_W  OBI write data.
- rvalid_i  in  1  OBI response valid (reads and writes).
- rdata_i  in  DATA_W  OBI read data.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- aborted_o  out  1  one-cycle abort-completion pulse, mutually exclusive with done_o.

Behaviour:
- Reset values: state=IDLE; req_o=0, we_o=0, addr_o=0, wdata_o=0, be_o=all-ones; busy_o=0, done_o=0, aborted_o=0; internal counter/buffer/abort latch=0.
- FSM states: IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, CMD_REQ, CMD_RSP, WAIT_FIN, DONE.
- IDLE:
  - start_i=1 latches src, dst, len, ctrl and clears the word counter.
  - len_i=0 goes directly to CMD_REQ (command is still issued).
  - Otherwise goes to RD_REQ.
  - start_i while not IDLE is ignored.
- RD_REQ: req_o=1, we_o=0, addr_o=src+4*idx. On gnt_i -> RD_RSP; req_o drops the cycle after the grant.
- RD_RSP: req_o=0. On rvalid_i, capture rdata_i into the word buffer -> WR_REQ.
- WR_REQ: req_o=1, we_o=1, addr_o=dst+4*idx, wdata_o=buffer. On gnt_i -> WR_RSP.
- WR_RSP: on rvalid_i, idx increments.
  - idx+1==len -> CMD_REQ.
  - Otherwise -> RD_REQ.
- CMD_REQ / CMD_RSP: same handshake as a write, with addr_o=ctrl_addr, wdata_o=ctrl_data. After the response -> WAIT_FIN.
- WAIT_FIN: stays until intr_ODIN_finished_i=1 -> DONE.
- DONE: done_o=1 for exactly one cycle -> IDLE. busy_o is still 1 in this cycle and 0 the next.
- Handshake rules:
  - At most one outstanding transaction.
  - While req_o=1 and gnt_i=0, addr_o, we_o, be_o and wdata_o stay stable.
  - req_o is never withdrawn before the grant.
  - rvalid_i outside RD_RSP/WR_RSP/CMD_RSP is ignored.
  - Grant and rvalid in the same cycle as the request are not possible; rvalid arrives at least 1 cycle after the grant.
- Arithmetic:
  - Addresses are computed as base + (idx<<2), modulo 2^ADDR_W; wrap-around is allowed and not flagged.
  - idx is LEN_W bits; len=2^LEN_W-1 is the maximum supported.
- Abort:
  - abort_i is latched.
  - In a *_REQ state with no grant yet, the FSM finishes the granted transaction before acting; req_o is never dropped early.
  - At the next *_RSP completion, or immediately in WAIT_FIN or IDLE-bound states, the FSM pulses aborted_o for 1 cycle -> IDLE.
  - Abort during WAIT_FIN -> aborted_o next cycle.
  - Abort in IDLE is ignored and not latched.
  - Abort and finish in the same WAIT_FIN cycle: abort wins.
- Latency:
  - Per word = read grant wait + read response + write grant wait + write response.
  - Minimum 4 cycles per word with zero-wait slaves (gnt_i same cycle as req_o, rvalid_i next cycle).
- Reset asserted mid-operation: all state and outputs return to reset values asynchronously; an in-flight bus response after reset is ignored.

Test Plan:
- Zero-wait slaves, src=0x1000, dst=0x2000, len=3, memory {A,B,C} -> writes A@0x2000, B@0x2004, C@0x2008, then ctrl_data@ctrl_addr; intr high 5 cycles later -> done_o 1 cycle; 4 cycles per word.
- Random gnt_i stalls of 0-5 cycles, len=16 -> address/wdata/we stable during every stall; destination contents match source.
- len=0 -> no read/write to src/dst; only the command write; done_o after intr.
- abort_i asserted during a stalled WR_REQ at word 2 of 8 -> write still completes at dst+8; aborted_o pulses; no further requests; done_o never set.
- start_i pulsed while busy -> ignored; transfer completes as the first start specified.
- RST asserted in RD_RSP, then late rvalid_i -> all outputs 0 (be_o all-ones), state IDLE, no capture.
